pito_mvu_dispatch: RTL and testbench
====================================

Name: pito_mvu_dispatch

Overview:
- Multi-hart job dispatcher between the pito barrel core and a single shared MVU.
- Each hart writes its MVU CSR set and pulses start. The block snapshots that hart's CSR bank into a per-hart job slot.
- It arbitrates pending jobs round-robin onto the MVU and returns the MVU completion interrupt to the owning hart only.
- Generalises the fixed per-hart CSR/start/irq bundle to parametrised hart count and CSR word count, and adds queuing, arbitration and ownership tracking.

Parameters:
- NUM_HARTS, 8, number of harts / job slots (>=2).
- CFG_WORDS, 31, 32-bit CSR words per job (base addrs, strides, lengths, precision, status, command, quant).
- HART_W, $clog2(NUM_HARTS), hart id width (derived).
- TIMEOUT_CYCLES, 65535, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  core clock
- pito_io_rst  in  1  reset, synchronous, active-high
- hart_start_i  in  NUM_HARTS  one-cycle start pulse per hart
- hart_cfg_i  in  32*CFG_WORDS*NUM_HARTS  live CSR words; hart h at bits [32*CFG_WORDS*(h+1)-1 : 32*CFG_WORDS*h]
- hart_busy_o  out  NUM_HARTS  slot h holds a pending or running job
- hart_irq_o  out  NUM_HARTS  one-cycle completion pulse to the owning hart
- hart_err_o  out  NUM_HARTS  one-cycle pulse: start rejected because the slot was busy
- hart_timeout_o  out  NUM_HARTS  one-cycle pulse: job aborted by watchdog
- mvu_cfg_o  out  32*CFG_WORDS  registered config of the issued job
- mvu_hart_o  out  HART_W  owner id of the issued/running job
- mvu_start_o  out  1  one-cycle start to MVU
- mvu_irq_i  in  1  MVU done pulse

Behaviour:
- Reset: all slots empty and snapshots zeroed; FSM to IDLE; rr pointer 0.
  - All outputs 0: hart_busy_o, hart_irq_o, hart_err_o, hart_timeout_o, mvu_cfg_o, mvu_hart_o, mvu_start_o.
  - Reset mid-job drops every job silently; no irq or timeout pulse is emitted.
- Accept: hart_start_i[h]=1 with pending[h]=0.
  - At that edge, pending[h] is set and hart h's CSR words are captured into snapshot[h].
  - Later CSR changes do not affect the queued job.
- Reject: hart_start_i[h]=1 with pending[h]=1.
  - Snapshot is unchanged; hart_err_o[h]=1 on the next cycle.
- hart_busy_o = pending register (no combinational path from hart_start_i).
- FSM states:
  - IDLE: if any pending bit is set and not yet issued, select the first set index at or after rr_ptr (wrapping at NUM_HARTS-1 -> 0). Load mvu_cfg_o from that snapshot and mvu_hart_o with the id; go to ISSUE. With no pending bits, stay in IDLE.
  - ISSUE: mvu_start_o=1 for exactly this cycle; go to RUN.
  - RUN: hold mvu_cfg_o and mvu_hart_o stable. On mvu_irq_i=1: hart_irq_o[owner]=1 next cycle, clear pending[owner], rr_ptr=owner+1 (wrapping), go to IDLE.
- Latency:
  - hart_start_i at cycle t (dispatcher idle) -> mvu_start_o at t+2.
  - mvu_irq_i at cycle t -> hart_irq_o at t+1.
  - Next job's mvu_start_o at t+2 at the earliest.
- mvu_irq_i outside RUN (IDLE/ISSUE) is ignored.
- Start for the owner in the same cycle as its completion: pending is still 1 that cycle, so the start is rejected (err pulse).
- Simultaneous starts from several harts are all accepted in one cycle; service order is round-robin from rr_ptr.
- Fairness: a hart waits at most NUM_HARTS-1 other jobs.

Optional Feature:
- Macro PITO_MVU_TIMEOUT_EN.
- Defined:
  - 32-bit counter cleared on entry to RUN, increments each RUN cycle.
  - When it reaches TIMEOUT_CYCLES without mvu_irq_i, the job is aborted: hart_timeout_o[owner]=1 next cycle (hart_irq_o stays 0), pending[owner] cleared, rr_ptr advanced, FSM to IDLE.
  - If mvu_irq_i arrives in the same cycle the limit is reached, irq wins.
- Undefined: no counter; hart_timeout_o tied 0; RUN waits indefinitely.

Test Plan:
- Single job: hart 3 start with wbaseaddr word=0x100 -> mvu_start_o 2 cycles later, mvu_hart_o=3, mvu_cfg_o word0=0x100. Irq 10 cycles later -> hart_irq_o=8'b0000_1000 for one cycle; busy[3] cleared.
- Snapshot isolation: hart 0 starts with quant=5, then changes CSR to 9 while queued behind hart 1 -> issued mvu_cfg_o quant field=5.
- Round-robin: harts 0,2,5 start in the same cycle at reset (rr_ptr=0) -> issue order 0,2,5. Hart 0 restarts during job 2 -> order continues 5 then 0.
- Busy reject: hart 4 starts twice, 3 cycles apart, before completion -> hart_err_o[4] pulses once; only one mvu_start_o for hart 4.
- Spurious irq and reset mid-job: mvu_irq_i in IDLE -> no hart_irq_o. pito_io_rst asserted in RUN -> all outputs 0 next cycle, no irq pulse; a later mvu_irq_i is ignored.
- With PITO_MVU_TIMEOUT_EN and TIMEOUT_CYCLES=20: no mvu_irq_i -> hart_timeout_o[owner] pulses 20 cycles after entering RUN, busy cleared, next pending job issued two cycles later.

Source files
------------

// File: rtl/pito_mvu_dispatch.sv
// Multi-hart MVU job dispatcher: per-hart CSR snapshots, round-robin issue, owner-only completion.
// Optional watchdog abort enabled by defining PITO_MVU_TIMEOUT_EN.
module pito_mvu_dispatch #(
  parameter int unsigned NUM_HARTS      = 8,
  parameter int unsigned CFG_WORDS      = 31,
  parameter int unsigned HART_W         = $clog2(NUM_HARTS),
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                                clk,
  input  logic                                pito_io_rst,
  input  logic [NUM_HARTS-1:0]                hart_start_i,
  input  logic [32*CFG_WORDS*NUM_HARTS-1:0]   hart_cfg_i,
  output logic [NUM_HARTS-1:0]                hart_busy_o,
  output logic [NUM_HARTS-1:0]                hart_irq_o,
  output logic [NUM_HARTS-1:0]                hart_err_o,
  output logic [NUM_HARTS-1:0]                hart_timeout_o,
  output logic [32*CFG_WORDS-1:0]             mvu_cfg_o,
  output logic [HART_W-1:0]                   mvu_hart_o,
  output logic                                mvu_start_o,
  input  logic                                mvu_irq_i
);

  localparam int unsigned CFG_W = 32 * CFG_WORDS;

  if (NUM_HARTS < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("pito_mvu_dispatch: NUM_HARTS must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RUN
  } state_e;

  state_e                 state_q;
  logic [NUM_HARTS-1:0]   pending_q;
  logic [NUM_HARTS-1:0]   pending_d;
  logic [CFG_W-1:0]       snap_q [NUM_HARTS];
  logic [HART_W-1:0]      rr_q;
  logic [CFG_W-1:0]       mvu_cfg_q;
  logic [HART_W-1:0]      mvu_hart_q;
  logic                   mvu_start_q;
  logic [NUM_HARTS-1:0]   irq_q;
  logic [NUM_HARTS-1:0]   err_q;

  logic [NUM_HARTS-1:0]   accept;
  logic [NUM_HARTS-1:0]   reject;
  logic [NUM_HARTS-1:0]   owner_oh;
  logic [NUM_HARTS-1:0]   clr_vec;
  logic                   done_hit;
  logic                   tmo_hit;
  logic                   finish;
  logic                   sel_found;
  logic [HART_W-1:0]      sel_idx;
  logic [HART_W-1:0]      cand;

  function automatic logic [HART_W-1:0] wrap_add(input logic [HART_W-1:0] a,
                                                 input int unsigned b);
    int unsigned s;
    s = 32'(a) + b;
    if (s >= NUM_HARTS) s = s - NUM_HARTS;
    return s[HART_W-1:0];
  endfunction

  assign accept   = hart_start_i & ~pending_q;
  assign reject   = hart_start_i & pending_q;
  assign owner_oh = NUM_HARTS'(1) << mvu_hart_q;
  assign done_hit = (state_q == S_RUN) && mvu_irq_i;
  assign finish   = done_hit || tmo_hit;
  assign clr_vec  = finish ? owner_oh : '0;
  // A completing owner still reads pending=1 this cycle, so its restart is rejected.
  assign pending_d = (pending_q & ~clr_vec) | accept;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_HARTS; i++) begin
      cand = wrap_add(rr_q, i);
      if (!sel_found && pending_q[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

`ifdef PITO_MVU_TIMEOUT_EN
  logic [31:0]          cnt_q;
  logic [NUM_HARTS-1:0] tmo_q;

  // Completion on the limit cycle wins over the abort.
  assign tmo_hit = (state_q == S_RUN) && !mvu_irq_i && (cnt_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (pito_io_rst) begin
      cnt_q <= '0;
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_hit ? owner_oh : '0;
      if (state_q == S_ISSUE) begin
        cnt_q <= '0;
      end else if (state_q == S_RUN) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign hart_timeout_o = tmo_q;
`else
  assign tmo_hit        = 1'b0;
  assign hart_timeout_o = '0;
`endif

  always_ff @(posedge clk) begin
    if (pito_io_rst) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      rr_q        <= '0;
      mvu_cfg_q   <= '0;
      mvu_hart_q  <= '0;
      mvu_start_q <= 1'b0;
      irq_q       <= '0;
      err_q       <= '0;
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
        snap_q[h] <= '0;
      end
    end else begin
      pending_q   <= pending_d;
      err_q       <= reject;
      irq_q       <= done_hit ? owner_oh : '0;
      mvu_start_q <= 1'b0;
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
        if (accept[h]) snap_q[h] <= hart_cfg_i[CFG_W*h +: CFG_W];
      end
      case (state_q)
        S_IDLE: begin
          if (sel_found) begin
            mvu_cfg_q   <= snap_q[sel_idx];
            mvu_hart_q  <= sel_idx;
            mvu_start_q <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (finish) begin
            rr_q    <= wrap_add(mvu_hart_q, 1);
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign hart_busy_o = pending_q;
  assign hart_irq_o  = irq_q;
  assign hart_err_o  = err_q;
  assign mvu_cfg_o   = mvu_cfg_q;
  assign mvu_hart_o  = mvu_hart_q;
  assign mvu_start_o = mvu_start_q;

endmodule

// File: tb/tb_pito_mvu_dispatch.sv
// Scoreboard bench for pito_mvu_dispatch: stimulus pushes expected issues and pulses, a negedge monitor pops and compares.
module tb_pito_mvu_dispatch;
  localparam int NH = 8;
  localparam int CW = 31;
  localparam int HW = 3;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NH-1:0]           hart_start = '0;
  logic [32*CW*NH-1:0]     cfg = '0;
  logic                    mvu_irq = 1'b0;
  logic [NH-1:0]           hart_busy_o, hart_irq_o, hart_err_o, hart_timeout_o;
  logic [32*CW-1:0]        mvu_cfg_o;
  logic [HW-1:0]           mvu_hart_o;
  logic                    mvu_start_o;

  pito_mvu_dispatch #(.NUM_HARTS(NH), .CFG_WORDS(CW), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .pito_io_rst(rst), .hart_start_i(hart_start), .hart_cfg_i(cfg),
    .hart_busy_o(hart_busy_o), .hart_irq_o(hart_irq_o), .hart_err_o(hart_err_o),
    .hart_timeout_o(hart_timeout_o), .mvu_cfg_o(mvu_cfg_o), .mvu_hart_o(mvu_hart_o),
    .mvu_start_o(mvu_start_o), .mvu_irq_i(mvu_irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int hart; logic [31:0] w0; logic [31:0] w30; int cyc; } issue_t;
  typedef struct { logic [NH-1:0] vec; int cyc; } pulse_t;

  issue_t iq[$];
  pulse_t irq_eq[$];
  pulse_t err_eq[$];
  pulse_t tmo_eq[$];

  int total = 0;
  int bad   = 0;

  task automatic mon_pulse(input string n, input logic [NH-1:0] v, input bit have, input pulse_t p);
    total++;
    if (!have) begin
      bad++;
      $display("FAIL %s_unexpected: got %b at cyc %0d, want no pulse", n, v, cyc);
    end else if (v !== p.vec || cyc != p.cyc) begin
      bad++;
      $display("FAIL %s: got %b at cyc %0d, want %b at cyc %0d", n, v, cyc, p.vec, p.cyc);
    end
  endtask

  issue_t m_e;
  pulse_t m_p;
  bit     m_have;
  always @(negedge clk) begin
    if (mvu_start_o) begin
      total++;
      if (iq.size() == 0) begin
        bad++;
        $display("FAIL issue_unexpected: got hart=%0d at cyc %0d, want no issue", mvu_hart_o, cyc);
      end else begin
        m_e = iq.pop_front();
        if (mvu_hart_o !== 3'(m_e.hart) || mvu_cfg_o[31:0] !== m_e.w0 ||
            mvu_cfg_o[32*30 +: 32] !== m_e.w30 || (m_e.cyc >= 0 && cyc != m_e.cyc)) begin
          bad++;
          $display("FAIL issue: got hart=%0d w0=%h w30=%h cyc=%0d, want hart=%0d w0=%h w30=%h cyc=%0d",
                   mvu_hart_o, mvu_cfg_o[31:0], mvu_cfg_o[32*30 +: 32], cyc,
                   m_e.hart, m_e.w0, m_e.w30, m_e.cyc);
        end
      end
    end
    if (hart_irq_o != '0) begin
      m_have = irq_eq.size() > 0;
      if (m_have) m_p = irq_eq.pop_front();
      mon_pulse("irq", hart_irq_o, m_have, m_p);
    end
    if (hart_err_o != '0) begin
      m_have = err_eq.size() > 0;
      if (m_have) m_p = err_eq.pop_front();
      mon_pulse("err", hart_err_o, m_have, m_p);
    end
    if (hart_timeout_o != '0) begin
      m_have = tmo_eq.size() > 0;
      if (m_have) m_p = tmo_eq.pop_front();
      mon_pulse("timeout", hart_timeout_o, m_have, m_p);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  64'(hart_busy_o), 64'h0);
    chk({tag, "_irq"},   64'(hart_irq_o), 64'h0);
    chk({tag, "_err"},   64'(hart_err_o), 64'h0);
    chk({tag, "_tmo"},   64'(hart_timeout_o), 64'h0);
    chk({tag, "_cfg"},   64'(|mvu_cfg_o), 64'h0);
    chk({tag, "_hart"},  64'(mvu_hart_o), 64'h0);
    chk({tag, "_start"}, 64'(mvu_start_o), 64'h0);
  endtask

  task automatic set_word(input int h, input int w, input logic [31:0] v);
    cfg[32*(CW*h + w) +: 32] = v;
  endtask

  task automatic exp_issue(input int h, input logic [31:0] w0, input logic [31:0] w30, input int c);
    issue_t e;
    e.hart = h; e.w0 = w0; e.w30 = w30; e.cyc = c;
    iq.push_back(e);
  endtask

  task automatic drive_start(input logic [NH-1:0] m);
    hart_start = m;
    step();
    hart_start = '0;
  endtask

  task automatic wait_issue(output int s);
    int n = 0;
    while (!mvu_start_o && n < 200) begin
      step();
      n++;
    end
    if (!mvu_start_o) begin
      total++;
      bad++;
      $display("FAIL issue_wait: got no mvu_start_o within 200 cycles, want a start");
    end
    s = cyc;
  endtask

  task automatic finish(input int owner, input int d);
    pulse_t p;
    repeat (d) step();
    mvu_irq = 1'b1;
    p.vec = NH'(1) << owner;
    p.cyc = cyc + 1;
    irq_eq.push_back(p);
    step();
    mvu_irq = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, want finish");
    $fatal(1);
  end

  initial begin
    int s;
    pulse_t p;
    for (int h = 0; h < NH; h++) set_word(h, 0, 32'h1000 + h);
    set_word(3, 0, 32'h100);
    rst = 1'b1;
    repeat (3) step();
    chk_zero("reset");
    rst = 1'b0;
    step();

    // Single job on hart 3: issue two cycles after start, irq one cycle after mvu_irq_i.
    exp_issue(3, 32'h100, 32'h0, cyc + 2);
    drive_start(8'h08);
    wait_issue(s);
    chk("t1_busy_run", 64'(hart_busy_o), 64'h08);
    finish(3, 10);
    chk("t1_busy_done", 64'(hart_busy_o), 64'h00);

    // Snapshot isolation: hart 0 queued behind hart 1, live CSR changes after accept.
    set_word(1, 30, 32'h7);
    exp_issue(1, 32'h1001, 32'h7, -1);
    drive_start(8'h02);
    wait_issue(s);
    set_word(0, 30, 32'h5);
    exp_issue(0, 32'h1000, 32'h5, -1);
    drive_start(8'h01);
    set_word(0, 30, 32'h9);
    chk("t2_busy", 64'(hart_busy_o), 64'h03);
    finish(1, 4);
    wait_issue(s);
    finish(0, 4);

    // Round-robin after reset: 0,2,5 together, hart 0 restarts during job 2.
    rst = 1'b1;
    step();
    chk_zero("rst2");
    rst = 1'b0;
    step();
    set_word(2, 30, 32'h22);
    set_word(5, 30, 32'h55);
    exp_issue(0, 32'h1000, 32'h9, -1);
    exp_issue(2, 32'h1002, 32'h22, -1);
    exp_issue(5, 32'h1005, 32'h55, -1);
    drive_start(8'b0010_0101);
    chk("t3_busy", 64'(hart_busy_o), 64'h25);
    wait_issue(s);
    finish(0, 3);
    wait_issue(s);
    set_word(0, 30, 32'h33);
    exp_issue(0, 32'h1000, 32'h33, -1);
    drive_start(8'h01);
    finish(2, 3);
    wait_issue(s);
    finish(5, 3);
    wait_issue(s);
    finish(0, 3);

    // Busy reject: second start on hart 4 three cycles later pulses err once.
    exp_issue(4, 32'h1004, 32'h0, -1);
    drive_start(8'h10);
    step();
    step();
    p.vec = 8'h10;
    p.cyc = cyc + 1;
    err_eq.push_back(p);
    drive_start(8'h10);
    finish(4, 5);
    repeat (5) step();
    chk("t4_busy", 64'(hart_busy_o), 64'h00);

    // Spurious irq in IDLE, then reset in the middle of a running job.
    mvu_irq = 1'b1;
    step();
    mvu_irq = 1'b0;
    chk("t5_spur_irq", 64'(hart_irq_o), 64'h0);
    exp_issue(6, 32'h1006, 32'h0, -1);
    drive_start(8'h40);
    wait_issue(s);
    repeat (3) step();
    rst = 1'b1;
    step();
    chk_zero("t5_rst");
    rst = 1'b0;
    mvu_irq = 1'b1;
    step();
    mvu_irq = 1'b0;
    chk("t5_post_irq", 64'(hart_irq_o), 64'h0);
    repeat (4) step();
    chk("t5_busy", 64'(hart_busy_o), 64'h0);

`ifdef PITO_MVU_TIMEOUT_EN
    // Watchdog: hart 2 never completes, hart 7 follows right after the abort.
    set_word(7, 30, 32'h77);
    exp_issue(2, 32'h1002, 32'h22, -1);
    drive_start(8'h84);
    wait_issue(s);
    p.vec = 8'h04;
    p.cyc = s + 21;
    tmo_eq.push_back(p);
    exp_issue(7, 32'h1007, 32'h77, s + 22);
    repeat (21) step();
    chk("t6_busy", 64'(hart_busy_o), 64'h80);
    wait_issue(s);
    finish(7, 2);
`endif

    repeat (5) step();
    chk("issue_q_empty", 64'(iq.size()), 64'h0);
    chk("irq_q_empty", 64'(irq_eq.size()), 64'h0);
    chk("err_q_empty", 64'(err_eq.size()), 64'h0);
    chk("tmo_q_empty", 64'(tmo_eq.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
